// File: rtl/processor_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, instruction byte
// count and the default reset PC.
package processor_pkg;

    typedef enum logic [1:0] {
        ST_REQ    = 2'd0,
        ST_WAIT   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } fetch_state_t;

    localparam int          INST_BYTES       = 4;
    localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction memory request/response channel plus the decode-side
// instruction handshake. The fetch stage is the master.
interface instruction_fetch_if #(
    parameter int WORDSIZE         = 64,
    parameter int INSTRUCTION_SIZE = 32
);
    logic                        imem_req_valid;
    logic                        imem_req_ready;
    logic [WORDSIZE-1:0]         imem_req_addr;
    logic                        imem_resp_valid;
    logic [INSTRUCTION_SIZE-1:0] imem_resp_data;
    logic                        inst_valid;
    logic                        inst_ready;
    logic [INSTRUCTION_SIZE-1:0] inst_data;
    logic [WORDSIZE-1:0]         inst_pc;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        output inst_valid, inst_data, inst_pc,
        input  inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        input  inst_valid, inst_data, inst_pc,
        output inst_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// Two-entry queue of {pc, instruction}. Slot 0 is always the head.
// Flush wins over push/pop; a simultaneous push and pop are both honoured.
module fetch_fifo #(
    parameter int PC_W   = 64,
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [PC_W-1:0]   push_pc,
    input  logic [INST_W-1:0] push_inst,
    output logic [PC_W-1:0]   head_pc,
    output logic [INST_W-1:0] head_inst,
    output logic [1:0]        count,
    output logic              full,
    output logic              empty
);
    logic [1:0][PC_W-1:0]   pc_q, pc_d;
    logic [1:0][INST_W-1:0] inst_q, inst_d;
    logic [1:0]             count_q, count_d;
    logic                   do_pop, do_push, wr_idx;

    // Next-state: shift on pop, write behind the surviving entries on push.
    always_comb begin
        pc_d    = pc_q;
        inst_d  = inst_q;
        count_d = count_q;
        do_pop  = pop && (count_q != 2'd0);
        do_push = push && ((count_q != 2'd2) || do_pop);
        wr_idx  = do_pop ? (count_q == 2'd2) : (count_q == 2'd1);
        if (flush) begin
            count_d = 2'd0;
        end else begin
            if (do_pop) begin
                pc_d[0]   = pc_q[1];
                inst_d[0] = inst_q[1];
            end
            if (do_push) begin
                pc_d[wr_idx]   = push_pc;
                inst_d[wr_idx] = push_inst;
            end
            count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    // Storage and occupancy registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= '0;
            inst_q  <= '0;
            count_q <= 2'd0;
        end else begin
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            count_q <= count_d;
        end
    end

    assign head_pc   = pc_q[0];
    assign head_inst = inst_q[0];
    assign count     = count_q;
    assign full      = (count_q == 2'd2);
    assign empty     = (count_q == 2'd0);
endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, keeps one imem request in flight,
// buffers up to two tagged instructions for decode, handles redirect/flush
// and halt. Optional macro IFETCH_ALIGN_CHECK_EN turns a misaligned
// redirect into a sticky fault that parks the stage in HALTED until reset;
// without it the low two target bits are simply cleared.
//
// state  | meaning
// REQ    | presenting (or allowed to present) a request at pc
// WAIT   | one request accepted, response pending, will be queued
// DRAIN  | one request accepted, response pending, will be discarded
// HALTED | misaligned redirect seen; idle until reset
module instruction_fetch
    import processor_pkg::*;
#(
    parameter int                   WORDSIZE         = 64,
    parameter int                   INSTRUCTION_SIZE = 32,
    parameter logic [WORDSIZE-1:0]  RESET_PC         = WORDSIZE'(DEFAULT_RESET_PC)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                halt,
    input  logic                redirect_en,
    input  logic [WORDSIZE-1:0] redirect_pc,
    output logic                fetch_fault,
    instruction_fetch_if.master bus
);
    localparam logic [WORDSIZE-1:0] PC_INC = WORDSIZE'(INSTRUCTION_SIZE / 8);

    fetch_state_t        state_q, state_d;
    logic [WORDSIZE-1:0] pc_q, pc_d;
    logic [WORDSIZE-1:0] tag_q, tag_d;
    logic                pend_q, pend_d;
    logic                fault_q, fault_d;
    logic                req_valid, accept, push, pop, flush;
    logic                misalign;
    logic [WORDSIZE-1:0] target;
    logic [1:0]          q_count;
    logic                q_full, q_empty;

`ifdef IFETCH_ALIGN_CHECK_EN
    assign misalign = (redirect_pc[1:0] != 2'b00);
    assign target   = redirect_pc;
`else
    assign misalign = 1'b0;
    assign target   = redirect_pc & ~WORDSIZE'(3);
`endif

    // A request once shown is held (pend_q) even if halt rises before accept.
    assign req_valid = !reset && (state_q == ST_REQ) &&
                       (pend_q || (!halt && (q_count < 2'd2)));
    assign accept    = req_valid && bus.imem_req_ready;
    assign pop       = !q_empty && bus.inst_ready;

    // Next-state and datapath control; redirect overrides all other events.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tag_d   = tag_q;
        pend_d  = pend_q;
        fault_d = fault_q;
        push    = 1'b0;
        flush   = 1'b0;
        if (state_q == ST_HALTED) begin
            pend_d = 1'b0;
        end else if (redirect_en) begin
            flush  = 1'b1;
            pend_d = 1'b0;
            if (misalign) begin
                fault_d = 1'b1;
                state_d = ST_HALTED;
            end else begin
                pc_d = target;
                unique case (state_q)
                    ST_REQ:   state_d = accept ? ST_DRAIN : ST_REQ;
                    ST_WAIT,
                    ST_DRAIN: state_d = bus.imem_resp_valid ? ST_REQ : ST_DRAIN;
                    default:  state_d = state_q;
                endcase
            end
        end else begin
            unique case (state_q)
                ST_REQ: begin
                    if (accept) begin
                        tag_d   = pc_q;
                        pc_d    = pc_q + PC_INC;
                        pend_d  = 1'b0;
                        state_d = ST_WAIT;
                    end else if (req_valid) begin
                        pend_d = 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (bus.imem_resp_valid) begin
                        push    = 1'b1;
                        state_d = ST_REQ;
                    end
                end
                ST_DRAIN: begin
                    if (bus.imem_resp_valid) state_d = ST_REQ;
                end
                default: state_d = state_q;
            endcase
        end
    end

    // State, PC, in-flight tag and sticky fault registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_REQ;
            pc_q    <= RESET_PC;
            tag_q   <= '0;
            pend_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tag_q   <= tag_d;
            pend_q  <= pend_d;
            fault_q <= fault_d;
        end
    end

    fetch_fifo #(
        .PC_W   (WORDSIZE),
        .INST_W (INSTRUCTION_SIZE)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .flush     (flush),
        .push_pc   (tag_q),
        .push_inst (bus.imem_resp_data),
        .head_pc   (bus.inst_pc),
        .head_inst (bus.inst_data),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = pc_q;
    assign bus.inst_valid     = !q_empty;
    assign fetch_fault        = fault_q;

    // q_full is only of interest to observers of the queue.
    logic unused_full;
    assign unused_full = q_full;
endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage directly upstream of the processor's datapath/control_unit pair. Owns the program counter, issues word requests to instruction memory over a valid/ready request channel, and accepts responses arriving a variable number of cycles later. Buffers up to two fetched instructions, tagged with their PCs, in a small queue and presents them to decode over a valid/ready handshake. Supports PC redirect (branch/jump) with flush and halting on the control unit's `finished`.

## Interface
- `WORDSIZE`, 64: PC and address width
- `INSTRUCTION_SIZE`, 32: instruction width; PC increment is INSTRUCTION_SIZE/8 = 4
- `RESET_PC`, 0: PC value loaded on reset
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-high reset
- `halt`  in  1  level; driven from `finished`; blocks new requests
- `imem_req_valid`  out  1  fetch request valid
- `imem_req_ready`  in  1  memory accepts the request this cycle
- `imem_req_addr`  out  WORDSIZE  fetch address
- `imem_resp_valid`  in  1  response data valid for one cycle
- `imem_resp_data`  in  INSTRUCTION_SIZE  fetched instruction
- `redirect_en`  in  1  single-cycle redirect strobe
- `redirect_pc`  in  WORDSIZE  redirect target
- `inst_valid`  out  1  queue head valid
- `inst_ready`  in  1  decode consumes the head
- `inst_data`  out  INSTRUCTION_SIZE  head instruction
- `inst_pc`  out  WORDSIZE  PC of head instruction
- `fetch_fault`  out  1  misaligned-redirect fault, sticky

## Operation
- FSM states: REQ, WAIT, DRAIN, HALTED.
- REQ: `imem_req_valid`=1 when `halt`=0 and queue occupancy < 2, with `imem_req_addr`=pc. On valid&ready: record pc as the in-flight tag, pc <= pc+4, go to WAIT.
- WAIT: on `imem_resp_valid`, push {tag, data} into the queue and go to REQ.
- At most one request in flight. The issue condition includes the in-flight slot, so a push never hits a full queue.
- Redirect has priority over every other event in the same cycle:
  - Queue is flushed.
  - pc <= `redirect_pc`.
  - From WAIT, go to DRAIN, or to REQ if the response arrives in that same cycle; that response is discarded.
  - From REQ, an unaccepted request is withdrawn, the single permitted exception to request stability. A request accepted in the redirect cycle goes to DRAIN.
- DRAIN: discard the next response, then go to REQ.
- Request stability: otherwise, once asserted, `imem_req_valid` and `imem_req_addr` hold until accepted.
- Queue pops on `inst_valid`&`inst_ready`. A push and a pop in the same cycle are both honoured.
- `halt`: no new requests are issued. An in-flight response still completes and the queue still drains. Deasserting `halt` resumes fetch.
- HALTED is entered only through the fault path (see Configuration). It is left only by reset.

## Timing
- Reset values: pc=RESET_PC, state=REQ, queue empty.
- Reset values of outputs: `imem_req_valid`=0 while `reset` is high, `inst_valid`=0, `fetch_fault`=0.
- `imem_req_valid` asserts in the first cycle after reset deasserts.
- Response-to-decode latency: `inst_valid` is high in the cycle after `imem_resp_valid`.
- Accept-to-next-request: in a zero-wait-state loop (response in the cycle after accept), throughput is one instruction per 2 cycles.
- Redirect-to-new-request: new address appears the cycle after `redirect_en` if nothing is in flight. Otherwise it appears the cycle after the drained response.
- `reset` mid-operation: all state clears immediately. Any later stale response is ignored, because WAIT/DRAIN are not active.

## Configuration
- Macro: `IFETCH_ALIGN_CHECK_EN`.
- Defined: `redirect_en` with `redirect_pc[1:0]`≠0 sets `fetch_fault`, flushes the queue and enters HALTED. Outstanding responses are discarded.
- Undefined: `redirect_pc[1:0]` is masked to 0 and `fetch_fault` is tied 0.

## Structure
- Shared `processor_pkg`: FSM state enum, INST_BYTES=4, default RESET_PC.
- Sub-module `fetch_fifo`: 2-entry queue of {pc, instruction} with push, pop, flush, count, full/empty.

## Test plan
- Reset release, memory always ready, 1-cycle response with data 0x00000013: requests at 0x0, 0x4, 0x8; `inst_pc` sequence 0x0, 0x4, 0x8; `inst_data`=0x00000013.
- `inst_ready`=0: exactly 2 entries buffered; `imem_req_valid` stays 0 until a pop.
- Redirect to 0x100 while in WAIT: late response for 0x8 is dropped; next request address is 0x100; queue is empty.
- Redirect and response in the same cycle: response discarded; request to target in the next cycle.
- `halt`=1 with one request in flight: response is queued; no further requests; releasing `halt` resumes at the next pc.
- `IFETCH_ALIGN_CHECK_EN` defined, redirect to 0x102: `fetch_fault`=1, no requests until reset. Macro undefined: fetch resumes at 0x100.
